// File: rtl/prog_sel_pkg.sv
// Shared program-select definitions: FSM states and bank sizes, so the display text tables and the selector agree.
// No logic here; no latency or backpressure.
package prog_sel_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    localparam int NUM_BLOCKS = 3;
    localparam int BLK0_CNT   = 10;
    localparam int BLK1_CNT   = 10;
    localparam int BLK2_CNT   = 5;

endpackage

// File: rtl/btn_debounce.sv
// Raw button to clean level and one-cycle press pulse (2-flop sync, debounce counter, rising-edge detect).
// Latency 2 + 2^DB_BITS + 1 cycles from a clean edge to btn_press; no backpressure, pulses are never held.
module btn_debounce #(
    parameter int DB_BITS = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);

    logic               sync_1;
    logic               sync_2;
    logic               level_d;
    logic [DB_BITS-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            level_d   <= 1'b0;
            btn_level <= 1'b0;
            btn_press <= 1'b0;
            cnt       <= '0;
        end else begin
            sync_1    <= btn_raw;
            sync_2    <= sync_1;
            level_d   <= btn_level;
            btn_press <= btn_level & ~level_d;
            // Any sample agreeing with the accepted level restarts the stability window.
            if (sync_2 == btn_level) begin
                cnt <= '0;
            end else if (&cnt) begin
                btn_level <= sync_2;
                cnt       <= '0;
            end else begin
                cnt <= cnt + DB_BITS'(1);
            end
        end
    end

endmodule

// File: rtl/prog_selector.sv
// Button front end choosing bank/program and issuing a req/ack load request to the program loader.
// Selection updates one cycle after a press pulse; presses while a load is in flight are dropped, not queued.
module prog_selector
    import prog_sel_pkg::*;
#(
    parameter int DB_BITS    = 20,
    parameter int NUM_BLOCKS = prog_sel_pkg::NUM_BLOCKS,
    parameter int BLK0_CNT   = prog_sel_pkg::BLK0_CNT,
    parameter int BLK1_CNT   = prog_sel_pkg::BLK1_CNT,
    parameter int BLK2_CNT   = prog_sel_pkg::BLK2_CNT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_bank,
    input  logic       btn_load,
    input  logic       load_ack,
    output logic [3:0] pick,
    output logic [1:0] block,
    output logic       load_req,
    output logic       busy
);

    localparam logic [3:0] LIM0       = 4'(BLK0_CNT);
    localparam logic [3:0] LIM1       = 4'(BLK1_CNT);
    localparam logic [3:0] LIM2       = 4'(BLK2_CNT);
    localparam logic [1:0] LAST_BLOCK = 2'(NUM_BLOCKS - 1);

    logic   up_press;
    logic   down_press;
    logic   bank_press;
    logic   load_press;
    logic   [3:0] lim;
    state_t state;

    btn_debounce #(.DB_BITS(DB_BITS)) u_up (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_up), .btn_level(), .btn_press(up_press)
    );
    btn_debounce #(.DB_BITS(DB_BITS)) u_down (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_down), .btn_level(), .btn_press(down_press)
    );
    btn_debounce #(.DB_BITS(DB_BITS)) u_bank (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_bank), .btn_level(), .btn_press(bank_press)
    );
    btn_debounce #(.DB_BITS(DB_BITS)) u_load (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_load), .btn_level(), .btn_press(load_press)
    );

    always_comb begin
        lim = LIM0;
        case (block)
            2'd1:    lim = LIM1;
            2'd2:    lim = LIM2;
            default: lim = LIM0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pick     <= 4'd0;
            block    <= 2'd0;
            load_req <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bank_press) begin
                        block <= (block == LAST_BLOCK) ? 2'd0 : block + 2'd1;
                        pick  <= 4'd0;
                    end else if (up_press && !down_press) begin
                        pick <= (pick == lim - 4'd1) ? 4'd0 : pick + 4'd1;
                    end else if (down_press && !up_press) begin
                        pick <= (pick == 4'd0) ? lim - 4'd1 : pick - 4'd1;
                    end
                    // A stale ack still high must not let a new request start.
                    if (load_press && !load_ack) begin
                        state    <= REQ;
                        load_req <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                REQ: begin
                    if (load_ack) begin
                        state    <= WAIT_REL;
                        load_req <= 1'b0;
                    end
                end
                WAIT_REL: begin
                    if (!load_ack) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    load_req <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
